// File: rtl/fp_vector_buffer.sv
// Shift buffer that gathers DEPTH float words into one vector and presents them in parallel.
// Holds the full vector until the consumer acks. Also has a clear input and an indexed read port.
module fp_vector_buffer #(
    parameter  int DATA_W       = 32,
    parameter  int DEPTH        = 161,
    parameter  bit CLEAR_ON_ACK = 1'b0,
    localparam int CNT_W        = $clog2(DEPTH + 1),
    localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    vec_valid,
    input  logic                    vec_ack,
    output logic [DEPTH*DATA_W-1:0] vec_data,
    output logic [CNT_W-1:0]        fill_count,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid
);

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t                        r_state, w_next;
    logic [DEPTH-1:0][DATA_W-1:0]  r_entry;
    logic [CNT_W-1:0]              r_fill_count;
    logic [DATA_W-1:0]             r_rd_data;
    logic                          r_rd_valid;
    logic                          w_accept;
    logic                          w_last;
    logic [DATA_W-1:0]             w_rd_word;

    // Only the clear gates acceptance here, so the clear/ack/accept priority falls out of the FSM.
    assign w_accept = in_valid && (r_state == S_FILL) && !clear;
    assign w_last   = (r_fill_count == CNT_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FILL;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        vec_valid = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = !clear;
                if (w_accept && w_last) w_next = S_FULL;
            end
            S_FULL: begin
                vec_valid = 1'b1;
                if (clear || vec_ack) w_next = S_FILL;
            end
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry      <= '0;
            r_fill_count <= '0;
        end else if (clear) begin
            r_entry      <= '0;
            r_fill_count <= '0;
        end else if (r_state == S_FULL && vec_ack) begin
            r_fill_count <= '0;
            if (CLEAR_ON_ACK) r_entry <= '0;
        end else if (w_accept) begin
            // Oldest word drifts toward entry 0; newest always lands at the top.
            for (int i = 0; i < DEPTH - 1; i++) r_entry[i] <= r_entry[i+1];
            r_entry[DEPTH-1] <= in_data;
            r_fill_count     <= r_fill_count + 1'b1;
        end
    end

    // Explicit compare mux keeps out-of-range indices (non power-of-two DEPTH) reading as zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) w_rd_word = r_entry[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= w_rd_word;
        end
    end

    assign vec_data   = r_entry;
    assign fill_count = r_fill_count;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_fp_vector_buffer.sv
// Drives three buffers with shared stimulus: DEPTH=4 retain, DEPTH=4 zero-on-ack, and DEPTH=1.
// Each buffer's outputs are compared against a word-history model.
module tb_fp_vector_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0, in_valid = 1'b0, vec_ack = 1'b0, rd_en = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0]  rd_idx = '0;

    logic        ir[3], vv[3], rv[3];
    logic [31:0] rd[3];
    logic [2:0]  fc[2];
    logic [0:0]  fc_c;
    logic [127:0] vd[2];
    logic [31:0] vd_c;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fp_vector_buffer #(.DATA_W(32), .DEPTH(4), .CLEAR_ON_ACK(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .vec_valid(vv[0]), .vec_ack(vec_ack), .vec_data(vd[0]),
        .fill_count(fc[0]), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd[0]), .rd_valid(rv[0]));

    fp_vector_buffer #(.DATA_W(32), .DEPTH(4), .CLEAR_ON_ACK(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .vec_valid(vv[1]), .vec_ack(vec_ack), .vec_data(vd[1]),
        .fill_count(fc[1]), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd[1]), .rd_valid(rv[1]));

    fp_vector_buffer #(.DATA_W(32), .DEPTH(1), .CLEAR_ON_ACK(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .vec_valid(vv[2]), .vec_ack(vec_ack), .vec_data(vd_c),
        .fill_count(fc_c), .rd_en(rd_en), .rd_idx(rd_idx[0]), .rd_data(rd[2]), .rd_valid(rv[2]));

    // Model: per buffer, the last DEPTH accepted words (oldest first), a count and a full flag.
    int          depth[3] = '{4, 4, 1};
    bit          coa[3]   = '{1'b0, 1'b1, 1'b0};
    int unsigned hist[3][4];
    int          cnt[3];
    bit          full[3];
    int unsigned m_rdd[3];
    bit          m_rdv[3];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 4; i++) hist[m][i] = 0;
            cnt[m] = 0; full[m] = 0; m_rdd[m] = 0; m_rdv[m] = 0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            int idx;
            idx = (m == 2) ? int'(rd_idx[0]) : int'(rd_idx);
            m_rdv[m] = rd_en;
            if (rd_en) m_rdd[m] = (idx < depth[m]) ? hist[m][idx] : 0;
            if (clear) begin
                for (int i = 0; i < 4; i++) hist[m][i] = 0;
                cnt[m] = 0; full[m] = 0;
            end else if (full[m] && vec_ack) begin
                cnt[m] = 0; full[m] = 0;
                if (coa[m]) for (int i = 0; i < 4; i++) hist[m][i] = 0;
            end else if (in_valid && !full[m]) begin
                for (int i = 0; i < depth[m] - 1; i++) hist[m][i] = hist[m][i+1];
                hist[m][depth[m]-1] = in_data;
                cnt[m]++;
                if (cnt[m] == depth[m]) full[m] = 1;
            end
        end
    endtask

    task automatic check_regs(string tag);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("%s vec_valid[%0d]", tag, m), vv[m], full[m]);
            chk($sformatf("%s fill_count[%0d]", tag, m), (m == 2) ? 64'(fc_c) : 64'(fc[m]), cnt[m]);
            chk($sformatf("%s rd_valid[%0d]", tag, m), rv[m], m_rdv[m]);
            chk($sformatf("%s rd_data[%0d]", tag, m), rd[m], m_rdd[m]);
            for (int i = 0; i < depth[m]; i++)
                chk($sformatf("%s entry[%0d][%0d]", tag, m, i),
                    (m == 2) ? 64'(vd_c) : 64'(vd[m][i*32 +: 32]), hist[m][i]);
        end
    endtask

    task automatic drive(bit v, logic [31:0] d, bit a, bit c, bit re, logic [1:0] ix);
        in_valid = v; in_data = d; vec_ack = a; clear = c; rd_en = re; rd_idx = ix;
    endtask

    // in_ready is combinational, so it is checked before the edge; registers after it.
    task automatic step(string tag);
        #1;
        for (int m = 0; m < 3; m++)
            chk($sformatf("%s in_ready[%0d]", tag, m), ir[m], !full[m] && !clear);
        @(posedge clk);
        model_step();
        #1;
        check_regs(tag);
    endtask

    logic [31:0] vecw[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    initial begin
        model_reset();
        #3;
        check_regs("reset");
        #9 rst_n = 1'b1;

        // Four back-to-back words fill the DEPTH=4 buffers.
        for (int i = 0; i < 4; i++) begin
            drive(1, vecw[i], 0, 0, 0, 0);
            step("t1_fill");
        end
        chk("t1 vec_valid", vv[0], 1'b1);
        chk("t1 entry0", vd[0][31:0], 32'h3F800000);
        chk("t1 entry3", vd[0][127:96], 32'h40800000);
        chk("t1 fill_count", fc[0], 3'd4);

        // Source holds a word while FULL; it is accepted only after the ack.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hDEADBEEF, 0, 0, 0, 0);
            step("t2_hold");
            chk("t2 held entry3", vd[0][127:96], 32'h40800000);
        end
        drive(1, 32'hDEADBEEF, 1, 0, 0, 0);
        step("t2_ack");
        drive(1, 32'hDEADBEEF, 0, 0, 0, 0);
        step("t2_accept");
        chk("t2 fill_count", fc[0], 3'd1);
        chk("t2 entry3", vd[0][127:96], 32'hDEADBEEF);

        // Second word, then clear with in_valid high.
        drive(1, 32'h41000000, 0, 0, 0, 0);
        step("t3_load");
        drive(1, 32'h41100000, 0, 1, 0, 0);
        #1 chk("t3 in_ready during clear", ir[0], 1'b0);
        step("t3_clear");
        chk("t3 fill_count", fc[0], 3'd0);
        chk("t3 vec_data", vd[0], 128'd0);

        // Zero-on-ack versus retain.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h50000000 + i, 0, 0, 0, 0);
            step("t4_fill");
        end
        drive(0, 0, 1, 0, 0, 0);
        step("t4_ack");
        chk("t4 retain entry0", vd[0][31:0], 32'h50000000);
        chk("t4 zeroed vec", vd[1], 128'd0);

        // Indexed read while FULL; DEPTH=1 sees index 1 as out of range.
        for (int i = 0; i < 4; i++) begin
            drive(1, vecw[i], 0, 0, 0, 0);
            step("t5_fill");
        end
        drive(0, 0, 0, 0, 1, 2'd2);
        step("t5_rd2");
        chk("t5 rd_data idx2", rd[0], 32'h40400000);
        chk("t5 rd_valid", rv[0], 1'b1);
        drive(0, 0, 0, 0, 1, 2'd1);
        step("t5_rd_oob");
        chk("t5 depth1 oob rd_data", rd[2], 32'd0);
        drive(0, 0, 1, 0, 0, 0);
        step("t5_ack");

        // Async reset at fill_count=3.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h60000000 + i, 0, 0, 0, 0);
            step("t6_fill");
        end
        chk("t6 fill_count pre", fc[0], 3'd3);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_regs("t6_async_rst");
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // DEPTH=1: each accept fills, ack between.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h70000000 + i, 0, 0, 0, 0);
            step("d1_acc");
            chk("d1 vec_valid", vv[2], 1'b1);
            drive(0, 0, 1, 0, 0, 0);
            step("d1_ack");
        end

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, 2'($urandom));
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
